// File: rtl/axi_stream_len_stripper_if.sv
// AXI-stream beat bundle used on both sides of the length stripper.
// The master drives data/valid/last; the slave returns ready.
interface axi_stream_len_stripper_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axi_stream_len_stripper.sv
// Consumer of length-prepended 64-bit streams: checks ID/LEN, strips the
// header, re-derives tlast from LEN and counts framing errors.
module axi_stream_len_stripper #(
  parameter logic [7:0] ID          = 8'hF0,
  parameter int         MAX_PKT_LEN = 64,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      clear_counters,
  axi_stream_len_stripper_if.slave  in_axis,
  axi_stream_len_stripper_if.master out_axis,
  output logic                      busy,
  output logic [31:0]               pkt_count,
  output logic [CNT_WIDTH-1:0]      err_id_count,
  output logic [CNT_WIDTH-1:0]      err_len_count
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] data_q;
  logic        vld_q;
  logic        last_q;

  logic        in_rdy;
  logic        xfer;
  logic        ld;
  logic        last_d;
  logic        inc_pkt;
  logic        inc_id;
  logic        inc_len;
  logic [15:0] hdr_len;
  logic        id_bad;
  logic        len_bad;
  logic        hdr_ok;
  logic        last_hit;
  logic        tl;

  assign hdr_len  = in_axis.tdata[15:0];
  assign id_bad   = in_axis.tdata[63:56] != ID;
  assign len_bad  = (hdr_len == 16'd0) || (hdr_len > MAX_LEN);
  assign hdr_ok   = ~id_bad & ~len_bad;
  assign last_hit = cnt_q == len_q;
  assign tl       = in_axis.tlast;

  always_comb begin
    in_rdy = 1'b0;
    unique case (state_q)
      HDR:     in_rdy = ena & ~vld_q;
      PAYLOAD: in_rdy = ~vld_q | out_axis.tready;
      DROP:    in_rdy = 1'b1;
      default: in_rdy = 1'b0;
    endcase
  end

  assign in_axis.tready = in_rdy & ~rst;
  assign xfer           = in_axis.tvalid & in_axis.tready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    last_d  = 1'b0;
    inc_pkt = 1'b0;
    inc_id  = 1'b0;
    inc_len = 1'b0;
    unique case (state_q)
      HDR: if (xfer) begin
        // ID is judged first so a packet bumps exactly one error counter
        unique case (1'b1)
          id_bad: begin
            inc_id = 1'b1;
            if (!tl) state_d = DROP;
          end
          ~id_bad & len_bad: begin
            inc_len = 1'b1;
            if (!tl) state_d = DROP;
          end
          hdr_ok & tl: inc_len = 1'b1;
          hdr_ok & ~tl: begin
            len_d   = hdr_len;
            cnt_d   = 16'd1;
            state_d = PAYLOAD;
          end
          default: ;
        endcase
      end
      PAYLOAD: if (xfer) begin
        ld     = 1'b1;
        last_d = last_hit | tl;
        unique case (1'b1)
          tl & last_hit: begin
            inc_pkt = 1'b1;
            state_d = HDR;
          end
          tl & ~last_hit: begin
            inc_len = 1'b1;
            state_d = HDR;
          end
          ~tl & last_hit: begin
            inc_len = 1'b1;
            state_d = DROP;
          end
          ~tl & ~last_hit: cnt_d = cnt_q + 16'd1;
          default: ;
        endcase
      end
      DROP: if (xfer && tl) state_d = HDR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else if (ld) begin
      vld_q  <= 1'b1;
      last_q <= last_d;
      data_q <= in_axis.tdata;
    end else if (out_axis.tready) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_axis.tdata  = data_q;
  assign out_axis.tvalid = vld_q;
  assign out_axis.tlast  = last_q;
  assign busy            = (state_q != HDR) | vld_q;

  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clear_counters) begin
      pkt_count     <= '0;
      err_id_count  <= '0;
      err_len_count <= '0;
    end else begin
      if (inc_pkt && pkt_count != '1)
        pkt_count <= pkt_count + 32'd1;
      if (inc_id && err_id_count != '1)
        err_id_count <= err_id_count + CNT_ONE;
      if (inc_len && err_len_count != '1)
        err_len_count <= err_len_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_axi_stream_len_stripper.sv
// Directed bench for the length stripper: framing, errors, counters,
// stalls, ena gating and mid-packet reset.
module tb_axi_stream_len_stripper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        clear_counters = 1'b0;
  logic        busy;
  logic [31:0] pkt_count;
  logic [2:0]  err_id_count;
  logic [2:0]  err_len_count;

  int checks = 0;
  int errors = 0;
  logic [64:0] outq[$];

  axi_stream_len_stripper_if in_axis ();
  axi_stream_len_stripper_if out_axis ();

  axi_stream_len_stripper #(
    .ID(8'hF0),
    .MAX_PKT_LEN(64),
    .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .clear_counters(clear_counters),
    .in_axis(in_axis),
    .out_axis(out_axis),
    .busy(busy),
    .pkt_count(pkt_count),
    .err_id_count(err_id_count),
    .err_len_count(err_len_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_axis.tvalid === 1'b1 && out_axis.tready === 1'b1)
      outq.push_back({out_axis.tlast, out_axis.tdata});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] pw(input int base, input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(base * 256) + 64'(i);
  endfunction

  function automatic logic [63:0] hdr(input logic [7:0] id, input logic [15:0] len);
    return {id, 40'h12_3456_789A, len};
  endfunction

  task automatic send(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    in_axis.tdata  = d;
    in_axis.tlast  = l;
    in_axis.tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (in_axis.tready !== 1'b1 && n < 200);
    if (in_axis.tready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got tready=%b required 1", in_axis.tready);
    end
    @(posedge clk);
    #1;
    in_axis.tvalid = 1'b0;
    in_axis.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] id, input logic [15:0] len,
                          input int n, input int base);
    send(hdr(id, len), n == 0);
    for (int i = 0; i < n; i++) send(pw(base, i), i == n - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got busy=%b required 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_axis.tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_tvalid got %b required 0", out_axis.tvalid);
    end
    checks++;
    if (out_axis.tlast !== 1'b0) begin
      errors++; $display("FAIL rst_tlast got %b required 0", out_axis.tlast);
    end
    checks++;
    if (out_axis.tdata !== 64'h0) begin
      errors++; $display("FAIL rst_tdata got %h required 0", out_axis.tdata);
    end
    checks++;
    if (in_axis.tready !== 1'b0) begin
      errors++; $display("FAIL rst_tready got %b required 0", in_axis.tready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b required 0", busy);
    end
    checks++;
    if ({pkt_count, err_id_count, err_len_count} !== 38'h0) begin
      errors++;
      $display("FAIL rst_counters got %0d/%0d/%0d required 0/0/0",
               pkt_count, err_id_count, err_len_count);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_axis.tready !== 1'b1) begin
      errors++; $display("FAIL post_rst_tready got %b required 1", in_axis.tready);
    end
  endtask

  task automatic test_good();
    outq.delete();
    send(hdr(8'hF0, 16'd3), 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(pw(1, i), i == 2);
      checks++;
      if ({out_axis.tvalid, out_axis.tlast, out_axis.tdata} !==
          {1'b1, i == 2, pw(1, i)}) begin
        errors++;
        $display("FAIL good_latency word %0d got v=%b l=%b d=%h required v=1 l=%b d=%h",
                 i, out_axis.tvalid, out_axis.tlast, out_axis.tdata, i == 2, pw(1, i));
      end
    end
    drain();
    checks++;
    if (outq.size() != 3) begin
      errors++; $display("FAIL good_count got %0d required 3", outq.size());
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL good_pkt got %0d required 1", pkt_count);
    end
  endtask

  task automatic test_bad_id();
    outq.delete();
    send_pkt(8'hA5, 16'd2, 2, 2);
    drain();
    checks++;
    if (outq.size() != 0) begin
      errors++; $display("FAIL badid_out got %0d words required 0", outq.size());
    end
    checks++;
    if (err_id_count !== 3'd1) begin
      errors++; $display("FAIL badid_cnt got %0d required 1", err_id_count);
    end
    send_pkt(8'hF0, 16'd2, 2, 3);
    drain();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("FAIL badid_next_count got %0d required 2", outq.size());
    end else begin
      checks++;
      if (outq[0] !== {1'b0, pw(3, 0)} || outq[1] !== {1'b1, pw(3, 1)}) begin
        errors++;
        $display("FAIL badid_next_data got %h %h required %h %h",
                 outq[0], outq[1], {1'b0, pw(3, 0)}, {1'b1, pw(3, 1)});
      end
    end
    checks++;
    if (pkt_count !== 32'd2) begin
      errors++; $display("FAIL badid_pkt got %0d required 2", pkt_count);
    end
  endtask

  task automatic test_short();
    outq.delete();
    send_pkt(8'hF0, 16'd4, 2, 4);
    drain();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("FAIL short_count got %0d required 2", outq.size());
    end else begin
      checks++;
      if (outq[0] !== {1'b0, pw(4, 0)} || outq[1] !== {1'b1, pw(4, 1)}) begin
        errors++;
        $display("FAIL short_data got %h %h required %h %h",
                 outq[0], outq[1], {1'b0, pw(4, 0)}, {1'b1, pw(4, 1)});
      end
    end
    checks++;
    if (err_len_count !== 3'd1) begin
      errors++; $display("FAIL short_err got %0d required 1", err_len_count);
    end
    checks++;
    if (busy !== 1'b0 || pkt_count !== 32'd2) begin
      errors++;
      $display("FAIL short_hdr got busy=%b pkt=%0d required busy=0 pkt=2", busy, pkt_count);
    end
  endtask

  task automatic test_long();
    outq.delete();
    send(hdr(8'hF0, 16'd2), 1'b0);
    for (int i = 0; i < 4; i++) send(pw(5, i), i == 3);
    drain();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("FAIL long_count got %0d required 2", outq.size());
    end else begin
      checks++;
      if (outq[1] !== {1'b1, pw(5, 1)}) begin
        errors++; $display("FAIL long_last got %h required %h", outq[1], {1'b1, pw(5, 1)});
      end
    end
    checks++;
    if (err_len_count !== 3'd2) begin
      errors++; $display("FAIL long_err got %0d required 2", err_len_count);
    end
    send_pkt(8'hF0, 16'd1, 1, 6);
    drain();
    checks++;
    if (outq.size() != 3 || outq[outq.size()-1] !== {1'b1, pw(6, 0)}) begin
      errors++; $display("FAIL long_next got %0d words required 3 ending %h",
                         outq.size(), {1'b1, pw(6, 0)});
    end
    checks++;
    if (pkt_count !== 32'd3) begin
      errors++; $display("FAIL long_pkt got %0d required 3", pkt_count);
    end
  endtask

  task automatic test_len_bounds();
    outq.delete();
    send_pkt(8'hF0, 16'd0, 1, 7);
    drain();
    checks++;
    if (err_len_count !== 3'd3) begin
      errors++; $display("FAIL len0 got %0d required 3", err_len_count);
    end
    send_pkt(8'hF0, 16'd65, 1, 8);
    drain();
    checks++;
    if (err_len_count !== 3'd4) begin
      errors++; $display("FAIL len65 got %0d required 4", err_len_count);
    end
    send_pkt(8'hF0, 16'd2, 0, 9);
    drain();
    checks++;
    if (err_len_count !== 3'd5) begin
      errors++; $display("FAIL hdr_only got %0d required 5", err_len_count);
    end
    send_pkt(8'hA5, 16'd0, 1, 10);
    drain();
    checks++;
    if (err_id_count !== 3'd2 || err_len_count !== 3'd5) begin
      errors++;
      $display("FAIL id_and_len got id=%0d len=%0d required id=2 len=5",
               err_id_count, err_len_count);
    end
    checks++;
    if (outq.size() != 0) begin
      errors++; $display("FAIL bounds_out got %0d words required 0", outq.size());
    end
  endtask

  task automatic test_clear();
    clear_counters = 1'b1;
    send(hdr(8'hA5, 16'd1), 1'b1);
    clear_counters = 1'b0;
    checks++;
    if ({pkt_count, err_id_count, err_len_count} !== 38'h0) begin
      errors++;
      $display("FAIL clear got %0d/%0d/%0d required 0/0/0",
               pkt_count, err_id_count, err_len_count);
    end
    repeat (9) send(hdr(8'h77, 16'd1), 1'b1);
    drain();
    checks++;
    if (err_id_count !== 3'd7) begin
      errors++; $display("FAIL saturate got %0d required 7", err_id_count);
    end
  endtask

  task automatic test_max_stall();
    bit   done;
    bit   held;
    int   stab_err;
    int   order_err;
    logic [63:0] hd;
    done = 0;
    held = 0;
    stab_err = 0;
    order_err = 0;
    hd = '0;
    outq.delete();
    fork
      begin
        send_pkt(8'hF0, 16'd64, 64, 256);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (held && (out_axis.tvalid !== 1'b1 || out_axis.tdata !== hd))
            stab_err++;
          held = out_axis.tvalid === 1'b1 && out_axis.tready === 1'b0;
          hd = out_axis.tdata;
          @(posedge clk);
          #1;
          out_axis.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_axis.tready = 1'b1;
    drain();
    checks++;
    if (outq.size() != 64) begin
      errors++; $display("FAIL stall_count got %0d required 64", outq.size());
    end else begin
      for (int i = 0; i < 64; i++)
        if (outq[i] !== {i == 63, pw(256, i)}) order_err++;
      checks++;
      if (order_err != 0) begin
        errors++; $display("FAIL stall_order got %0d bad words required 0", order_err);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL stall_stable got %0d changes required 0", stab_err);
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL stall_pkt got %0d required 1", pkt_count);
    end
  endtask

  task automatic test_ena();
    int bad;
    bad = 0;
    outq.delete();
    send(hdr(8'hF0, 16'd3), 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) send(pw(11, i), i == 2);
    drain();
    checks++;
    if (outq.size() != 3 || outq[outq.size()-1] !== {1'b1, pw(11, 2)}) begin
      errors++; $display("FAIL ena_finish got %0d words required 3", outq.size());
    end
    checks++;
    if (pkt_count !== 32'd2) begin
      errors++; $display("FAIL ena_pkt got %0d required 2", pkt_count);
    end
    in_axis.tdata  = hdr(8'hF0, 16'd1);
    in_axis.tlast  = 1'b0;
    in_axis.tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_axis.tready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ena_hold got %0d ready cycles required 0", bad);
    end
    @(posedge clk);
    #1;
    ena = 1'b1;
    send(hdr(8'hF0, 16'd1), 1'b0);
    send(pw(12, 0), 1'b1);
    drain();
    checks++;
    if (pkt_count !== 32'd3) begin
      errors++; $display("FAIL ena_resume got %0d required 3", pkt_count);
    end
  endtask

  task automatic test_rst_mid();
    outq.delete();
    send(hdr(8'hF0, 16'd3), 1'b0);
    out_axis.tready = 1'b0;
    send(pw(13, 0), 1'b0);
    checks++;
    if (out_axis.tvalid !== 1'b1 || out_axis.tdata !== pw(13, 0)) begin
      errors++;
      $display("FAIL rstmid_held got v=%b d=%h required v=1 d=%h",
               out_axis.tvalid, out_axis.tdata, pw(13, 0));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_axis.tvalid !== 1'b0 || busy !== 1'b0 || pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%b busy=%b pkt=%0d required 0/0/0",
               out_axis.tvalid, busy, pkt_count);
    end
    out_axis.tready = 1'b1;
    send_pkt(8'hF0, 16'd1, 1, 14);
    drain();
    checks++;
    if (outq.size() != 1 || outq[0] !== {1'b1, pw(14, 0)}) begin
      errors++;
      $display("FAIL rstmid_recover got %0d words required 1 of %h",
               outq.size(), {1'b1, pw(14, 0)});
    end
    checks++;
    if (pkt_count !== 32'd1) begin
      errors++; $display("FAIL rstmid_pkt got %0d required 1", pkt_count);
    end
  endtask

  initial begin
    in_axis.tdata   = '0;
    in_axis.tvalid  = 1'b0;
    in_axis.tlast   = 1'b0;
    out_axis.tready = 1'b1;
    test_reset();
    test_good();
    test_bad_id();
    test_short();
    test_long();
    test_len_bounds();
    test_clear();
    test_max_stall();
    test_ena();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
